// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1/2 stop) with 2-of-3 majority sampling.
// Word commits one cycle after the final stop-bit tick; the held word stays stable while o_valid && !i_ready.
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int NB_STOP    = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_bit,
  input  logic               i_tick,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break,
  output logic               o_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NB_DATA + 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S0    = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] CNT_S1    = CW'(OVERSAMPLE - 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t             state;
  logic               rx_meta, rxs;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shreg;
  logic               samp0, samp1;
  logic               perr, ferr, stop_low, par_low;
  logic               bit_val, ferr_next, stop_low_next, par_exp, commit, brk_det;

  always_comb begin
    bit_val       = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    ferr_next     = ferr | ~bit_val;
    stop_low_next = stop_low & ~bit_val;
    par_exp       = (PARITY_ODD != 0) ? ~^shreg : ^shreg;
    commit        = i_tick && (state == STOP) && (cnt == CNT_LAST) && (bit_cnt == STOP_LAST);
    // Break: line low through data, parity and every stop bit
    brk_det       = (shreg == '0) && par_low && stop_low_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_bit;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      samp0        <= 1'b0;
      samp1        <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      stop_low     <= 1'b0;
      par_low      <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            cnt      <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            stop_low <= 1'b1;
            par_low  <= 1'b1;
          end
        end
        START: begin
          if (i_tick) begin
            if (cnt == CNT_HALF) begin
              cnt <= '0;
              if (rxs) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA, PARITY, STOP: begin
          if (i_tick) begin
            if (cnt == CNT_S0) samp0 <= rxs;
            if (cnt == CNT_S1) samp1 <= rxs;
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              case (state)
                DATA: begin
                  shreg <= {bit_val, shreg[NB_DATA-1:1]};
                  if (bit_cnt == DATA_LAST) begin
                    bit_cnt <= '0;
                    state   <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
                PARITY: begin
                  perr    <= (bit_val != par_exp);
                  par_low <= ~bit_val;
                  state   <= STOP;
                end
                default: begin
                  ferr     <= ferr_next;
                  stop_low <= stop_low_next;
                  if (bit_cnt == STOP_LAST) begin
                    state <= brk_det ? BRK_WAIT : IDLE;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
              endcase
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        BRK_WAIT: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A commit wins over a same-cycle consume; an unconsumed word is overwritten
      if (commit) begin
        o_valid   <= 1'b1;
        o_overrun <= o_valid && !i_ready;
        if (brk_det) begin
          o_data       <= '0;
          o_parity_err <= 1'b0;
          o_frame_err  <= 1'b1;
          o_break      <= 1'b1;
        end else begin
          o_data       <= shreg;
          o_parity_err <= perr;
          o_frame_err  <= ferr_next;
          o_break      <= 1'b0;
        end
      end else if (o_valid && i_ready) begin
        o_valid      <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
        o_break      <= 1'b0;
        o_overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 8E1, 7O2) on separate lines, shared tick and ready.
// A frame-level model predicts each delivered word; literal checks pin the model and the latency.
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [8:0] dat;
    logic       pe;
    logic       fe;
    logic       bk;
    logic       ov;
  } word_t;

  int nbd  [3] = '{8, 8, 7};
  int pen  [3] = '{0, 1, 1};
  int podd [3] = '{0, 0, 1};
  int nst  [3] = '{1, 1, 2};

  logic       clk;
  logic       rst_n;
  logic [2:0] line;
  logic       tick;
  logic       rdy;
  logic [2:0] vld, pe, fe, bk, ov;
  logic [7:0] dat_a, dat_b;
  logic [6:0] dat_c;
  logic [8:0] dat [3];

  assign dat[0] = {1'b0, dat_a};
  assign dat[1] = {1'b0, dat_b};
  assign dat[2] = {2'b00, dat_c};

  uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .NB_STOP(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_bit(line[0]), .i_tick(tick), .i_ready(rdy),
    .o_valid(vld[0]), .o_data(dat_a), .o_parity_err(pe[0]), .o_frame_err(fe[0]),
    .o_break(bk[0]), .o_overrun(ov[0]));

  uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .NB_STOP(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_bit(line[1]), .i_tick(tick), .i_ready(rdy),
    .o_valid(vld[1]), .o_data(dat_b), .o_parity_err(pe[1]), .o_frame_err(fe[1]),
    .o_break(bk[1]), .o_overrun(ov[1]));

  uart_rx_cfg #(.NB_DATA(7), .OVERSAMPLE(16), .NB_STOP(2), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
    .i_clk(clk), .i_rst(rst_n), .i_bit(line[2]), .i_tick(tick), .i_ready(rdy),
    .o_valid(vld[2]), .o_data(dat_c), .o_parity_err(pe[2]), .o_frame_err(fe[2]),
    .o_break(bk[2]), .o_overrun(ov[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    rise_cyc = 0;
  int    rises [3] = '{0, 0, 0};
  logic  [2:0] pv = 3'b000;
  word_t expq [3][$];
  word_t last [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Expected word for one frame, derived from the frame's bit values
  function automatic word_t model_word(input int d, input logic [8:0] data, input logic pbit,
                                       input logic [1:0] stops);
    word_t      w;
    logic [8:0] m;
    logic       exp_p;
    bit         any_low, all_low;
    m       = data & ((9'd1 << nbd[d]) - 9'd1);
    exp_p   = (podd[d] != 0) ? ~^m : ^m;
    any_low = 1'b0;
    all_low = 1'b1;
    for (int i = 0; i < nst[d]; i++) begin
      if (!stops[i]) any_low = 1'b1;
      else all_low = 1'b0;
    end
    w.dat = m;
    w.pe  = (pen[d] != 0) && (pbit !== exp_p);
    w.fe  = any_low;
    w.bk  = 1'b0;
    w.ov  = 1'b0;
    if (m == 9'd0 && (pen[d] == 0 || !pbit) && all_low) begin
      w.dat = 9'd0;
      w.pe  = 1'b0;
      w.fe  = 1'b1;
      w.bk  = 1'b1;
    end
    return w;
  endfunction

  task automatic model_push(input int d, input word_t w);
    word_t x;
    x = w;
    if (expq[d].size() > 0 && !rdy) begin
      x.ov = 1'b1;
      expq[d][expq[d].size()-1] = x;
    end else begin
      expq[d].push_back(x);
    end
  endtask

  // One tick period (2 clocks) with line d driven to v, all other lines idle
  task automatic tp(input int d, input logic v);
    line    = 3'b111;
    line[d] = v;
    tick    = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int nbits);
    for (int i = 0; i < nbits * 16; i++) tp(0, 1'b1);
  endtask

  // A low final stop bit returns high after 10 ticks unless hold_low, so no start is seen after it
  task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int glitch, input bit hold_low);
    logic fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < nbd[d]; i++) fb.push_back(data[i]);
    if (pen[d] != 0) fb.push_back(pbit);
    for (int i = 0; i < nst[d]; i++) fb.push_back(stops[i]);
    for (int b = 0; b < fb.size(); b++) begin
      if (b == fb.size() - 1) model_push(d, model_word(d, data, pbit, stops));
      for (int t = 0; t < 16; t++) begin
        logic v;
        v = fb[b];
        if (glitch >= 0 && b == glitch + 1 && t == 7) v = ~v;
        if (b == fb.size() - 1 && !fb[b] && !hold_low && t >= 10) v = 1'b1;
        tp(d, v);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vld[d] && !pv[d]) begin
        rises[d]++;
        if (d == 0) rise_cyc = cyc;
      end
      pv[d] = vld[d];
      if (vld[d]) begin
        tests++;
        if (expq[d].size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid dut%0d: o_valid=1 data=%0h, expected no word", d, dat[d]);
        end else if (rdy) begin
          word_t e, a;
          e = expq[d].pop_front();
          a.dat = dat[d];
          a.pe  = pe[d];
          a.fe  = fe[d];
          a.bk  = bk[d];
          a.ov  = ov[d];
          last[d] = a;
          tests++;
          if (a !== e) begin
            fails++;
            $display("FAIL word dut%0d: got data=%0h pe=%b fe=%b brk=%b ovr=%b, expected data=%0h pe=%b fe=%b brk=%b ovr=%b",
                     d, a.dat, a.pe, a.fe, a.bk, a.ov, e.dat, e.pe, e.fe, e.bk, e.ov);
          end
        end
      end
    end
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    line  = 3'b111;
    tick  = 1'b0;
    rdy   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {29'd0, vld}, 0);
    chk("reset_data_a", {23'd0, dat[0]}, 0);
    chk("reset_flags", {20'd0, pe, fe, bk, ov}, 0);
    rst_n = 1'b1;
    idle(2);

    // 8N1 0xA5: 8 START + 128 DATA + 16 STOP ticks, tick every 2 clocks, 2-cycle sync + IDLE cycle
    c0 = cyc;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 1'b0);
    idle(2);
    chk("a5_latency", rise_cyc - c0, 307);
    chk("a5_data", {23'd0, last[0].dat}, 32'h0A5);
    chk("a5_flags", {28'd0, last[0].pe, last[0].fe, last[0].bk, last[0].ov}, 0);

    // 8E1 0x03: even parity expects 0
    send_frame(1, 9'h003, 1'b1, 2'b11, -1, 1'b0);
    idle(2);
    chk("8e1_p1_data", {23'd0, last[1].dat}, 32'h03);
    chk("8e1_p1_perr", {31'd0, last[1].pe}, 1);
    send_frame(1, 9'h003, 1'b0, 2'b11, -1, 1'b0);
    idle(2);
    chk("8e1_p0_perr", {31'd0, last[1].pe}, 0);

    // 7O2 0x41 (two ones -> odd parity bit 1), second stop low
    send_frame(2, 9'h041, 1'b1, 2'b01, -1, 1'b0);
    idle(2);
    chk("7o2_data", {23'd0, last[2].dat}, 32'h41);
    chk("7o2_flags", {28'd0, last[2].pe, last[2].fe, last[2].bk, last[2].ov}, 32'b0100);

    // False start, then 0x3C with a one-tick glitch mid data bit 2
    for (int i = 0; i < 5; i++) tp(0, 1'b0);
    idle(3);
    chk("false_start_no_word", rises[0], 1);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 2, 1'b0);
    idle(2);
    chk("glitch_data", {23'd0, last[0].dat}, 32'h3C);
    chk("glitch_words", rises[0], 2);

    // Overrun
    rdy = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, 1'b0);
    idle(1);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1'b0);
    idle(1);
    chk("ovr_valid", {31'd0, vld[0]}, 1);
    chk("ovr_data", {23'd0, dat[0]}, 32'h22);
    chk("ovr_flag", {31'd0, ov[0]}, 1);
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("ovr_consumed_valid", {31'd0, vld[0]}, 0);
    chk("ovr_consumed_flag", {31'd0, ov[0]}, 0);
    rdy = 1'b1;

    // Break: line low for 3 frame times
    send_frame(0, 9'h000, 1'b0, 2'b00, -1, 1'b1);
    for (int i = 0; i < 20 * 16; i++) tp(0, 1'b0);
    idle(2);
    chk("break_words", rises[0], 4);
    chk("break_data", {23'd0, last[0].dat}, 0);
    chk("break_flags", {28'd0, last[0].pe, last[0].fe, last[0].bk, last[0].ov}, 32'b0110);
    send_frame(0, 9'h096, 1'b0, 2'b11, -1, 1'b0);
    idle(2);
    chk("after_break_data", {23'd0, last[0].dat}, 32'h96);
    chk("after_break_brk", {31'd0, last[0].bk}, 0);

    // Reset mid-DATA with a held word
    rdy = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1, 1'b0);
    idle(1);
    chk("pre_reset_held", {23'd0, dat[0]}, 32'h5A);
    for (int i = 0; i < 16; i++) tp(0, 1'b0);
    for (int i = 0; i < 48; i++) tp(0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", {29'd0, vld}, 0);
    chk("rst_data", {23'd0, dat[0]}, 0);
    chk("rst_flags", {28'd0, pe[0], fe[0], bk[0], ov[0]}, 0);
    expq[0].delete();
    rst_n = 1'b1;
    idle(12);
    rdy = 1'b1;
    idle(1);

    chk("words_a", rises[0], 6);
    chk("words_b", rises[1], 2);
    chk("words_c", rises[2], 1);
    for (int d = 0; d < 3; d++) chk("pending_words", expq[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver in the MIPS debug/loader path. It deserialises one asynchronous serial line into parallel words and supports 5–9 data bits, optional even/odd parity and 1 or 2 stop bits. It uses majority-vote sampling and reports parity, framing, break and overrun status. Words are delivered through a valid/ready handshake, so the consumer (loader FSM or FIFO) may stall.

## Interface
- NB_DATA, 8: data bits per frame, legal 5..9.
- OVERSAMPLE, 16: i_tick pulses per bit period, even, ≥8.
- NB_STOP, 1: stop bits, 1 or 2.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- i_clk  in  1  single clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_bit  in  1  asynchronous serial line, idle high.
- i_tick  in  1  one-cycle pulse at OVERSAMPLE × baud.
- i_ready  in  1  consumer accepts the word when high with o_valid.
- o_valid  out  1  word and status available.
- o_data  out  NB_DATA  received word, LSB = first data bit on the line.
- o_parity_err  out  1  parity mismatch on the held word.
- o_frame_err  out  1  at least one stop bit was sampled low.
- o_break  out  1  break condition detected.
- o_overrun  out  1  the held word overwrote an unconsumed word.

## Operation
- The line passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value (rxs).
- Tick counter cnt is $clog2(OVERSAMPLE) bits wide and advances only on i_tick. Bit counter is $clog2(NB_DATA+1) bits wide.
- IDLE: rxs==0 → START, cnt=0.
- START: when cnt==OVERSAMPLE/2-1 on a tick, check rxs:
  - rxs==1 → false start, return to IDLE, no output.
  - rxs==0 → go to DATA with cnt=0, bit counter=0.
- Bit sampling (DATA, PARITY, STOP): take rxs on the ticks where cnt = OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1. The bit value is the 2-of-3 majority, decided on the cnt=OVERSAMPLE-1 tick; cnt then wraps to 0.
- DATA: each decided bit shifts in MSB-side, filling right-to-left, so after NB_DATA bits the first bit is at o_data[0]. After NB_DATA bits go to PARITY if PARITY_EN, else STOP.
- PARITY: expected bit = ^data when even, ~^data when odd. A mismatch sets the parity-error shadow.
- STOP: NB_STOP bits are decided; any bit decided 0 sets the framing-error shadow. After the last stop decision the frame commits:
  - Break: all data bits 0, parity bit (if any) 0 and stop sampled 0. Commit with o_break=1, o_frame_err=1, o_data=0, o_parity_err=0, then go to BRK_WAIT.
  - Otherwise go to IDLE immediately, at mid stop bit.
- BRK_WAIT: stay until rxs==1, then go to IDLE. No start is detected while in BRK_WAIT.
- Commit and handshake:
  - Commit loads o_data and all flags and sets o_valid=1.
  - Outputs stay stable while o_valid && !i_ready.
  - A cycle with o_valid && i_ready clears o_valid and all flags on the next edge, unless a commit occurs in the same cycle, in which case the new word loads.
  - A commit while o_valid && !i_ready overwrites the word with o_overrun=1.
- Reset: state IDLE, counters 0, shift register 0, all outputs 0. Reset mid-frame discards the frame, and no o_valid follows.

## Timing
- The synchroniser adds 2 cycles of latency from i_bit to rxs.
- Frame length in ticks from the START entry:
  - START: OVERSAMPLE/2.
  - DATA: NB_DATA·OVERSAMPLE.
  - PARITY: PARITY_EN·OVERSAMPLE.
  - STOP: NB_STOP·OVERSAMPLE.
- o_valid rises on the clock edge following the tick cycle of the final stop decision.
- The receiver is re-armed for a new start half a bit before the nominal end of the frame.
- Ticks arriving in IDLE or BRK_WAIT are ignored. If i_tick is 0, nothing advances except the synchroniser and the handshake.

## Test plan
- 8N1 with OVERSAMPLE=16, byte 0xA5, i_ready=1 → single o_valid pulse, o_data=0xA5, all flags 0.
- 8E1 with byte 0x03 and parity bit 1 → o_data=0x03, o_parity_err=1. Repeat with parity bit 0 → o_parity_err=0.
- 7O2 with byte 0x41 and the second stop bit driven low → o_data=0x41, o_frame_err=1, o_break=0.
- Line low for 5 ticks, then high → no o_valid. A valid 0x3C frame sent afterwards is received correctly. A single-tick glitch inside a data bit does not change the decided value.
- Frames 0x11 and 0x22 sent with i_ready=0 → o_data=0x22, o_overrun=1. After i_ready=1 for one cycle, o_valid=0 and o_overrun=0.
- Line held low for 3 frame times → one word with o_data=0, o_break=1, o_frame_err=1, and no further words until the line returns high. Separately, assert i_rst=0 mid-DATA → outputs 0 and no o_valid for that frame.
